// File: rtl/button_pkg.sv
// Shared types and 100 MHz default timing for the front-panel button conditioner.
package button_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    ARM_PRESS,
    PRESSED,
    ARM_RELEASE
  } btn_state_e;

  // 10 ms stability window, 500 ms initial repeat delay, 100 ms repeat period
  localparam int unsigned DEF_STABLE_CYCLES = 1_000_000;
  localparam int unsigned DEF_REPEAT_DELAY  = 50_000_000;
  localparam int unsigned DEF_REPEAT_PERIOD = 10_000_000;

  // Counter width for a count that reaches n-1; never narrower than one bit
  function automatic int unsigned ctr_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: two-flop synchroniser, stability-count debounce FSM and auto-repeat timer.
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  input  logic repeat_en_i,
  output logic db_o,
  output logic press_o,
  output logic release_o,
  output logic repeat_o
);

  localparam int unsigned CNT_W = ctr_width(STABLE_CYCLES);
  localparam int unsigned RC_W  = ctr_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RC_W-1:0]  DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0]  PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);

  logic [1:0]       sync_q;
  logic             s;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RC_W-1:0]  rc_q, rc_d;
  logic [RC_W-1:0]  rc_last;
  logic             first_q, first_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_q, repeat_d;

  assign s = sync_q[1];

  // Synchronise the asynchronous raw input into the clk domain
  always_ff @(posedge clk_i) begin
    if (reset_i) sync_q <= '0;
    else         sync_q <= {sync_q[0], raw_i};
  end

  // State, counters and registered strobes
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      rc_q      <= '0;
      first_q   <= 1'b1;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rc_q      <= rc_d;
      first_q   <= first_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
    end
  end

  // Debounce transitions and repeat timing; strobes only fire on exclusive transitions
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rc_d      = rc_q;
    first_d   = first_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    rc_last   = first_q ? DELAY_LAST : PERIOD_LAST;

    unique case (state_q)
      RELEASED: begin
        if (s) begin
          state_d = ARM_PRESS;
          cnt_d   = CNT_W'(1);
        end
      end
      ARM_PRESS: begin
        if (!s) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          press_d = 1'b1;
          rc_d    = '0;
          first_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = ARM_RELEASE;
          cnt_d   = CNT_W'(1);
        end else if (repeat_en_i) begin
          if (rc_q == rc_last) begin
            repeat_d = 1'b1;
            rc_d     = '0;
            first_d  = 1'b0;
          end else begin
            rc_d = rc_q + RC_W'(1);
          end
        end
      end
      ARM_RELEASE: begin
        // rc is left untouched here so a release bounce resumes repeat timing
        if (s) begin
          state_d = PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RELEASED;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = RELEASED;
    endcase

    // Disabled repeat pins the timer so re-enabling waits the full initial delay
    if (!repeat_en_i) begin
      rc_d    = '0;
      first_d = 1'b1;
    end
  end

  assign db_o      = (state_q == PRESSED) || (state_q == ARM_RELEASE);
  assign press_o   = press_q;
  assign release_o = release_q;
  assign repeat_o  = repeat_q;

endmodule

// File: rtl/button_bank_debouncer.sv
// N-channel pushbutton conditioner: per-channel polarity inversion, debounce and strobes.
module button_bank_debouncer
  import button_pkg::*;
#(
  parameter int unsigned     N_CH          = 5,
  parameter int unsigned     STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int unsigned     REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned     REPEAT_PERIOD = DEF_REPEAT_PERIOD,
  parameter logic [N_CH-1:0] INVERT        = '0
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic [N_CH-1:0] button_i,
  input  logic [N_CH-1:0] repeat_en_i,
  output logic [N_CH-1:0] db_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] repeat_o,
  output logic            any_press_o
);

  logic any_press_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_channel #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk_i      (clk_i),
      .reset_i    (reset_i),
      .raw_i      (button_i[i] ^ INVERT[i]),
      .repeat_en_i(repeat_en_i[i]),
      .db_o       (db_o[i]),
      .press_o    (press_o[i]),
      .release_o  (release_o[i]),
      .repeat_o   (repeat_o[i])
    );
  end

  // Single summary press strobe for logic that does not care which button
  always_ff @(posedge clk_i) begin
    if (reset_i) any_press_q <= 1'b0;
    else         any_press_q <= |press_o;
  end

  assign any_press_o = any_press_q;

endmodule

// File: tb/tb_button_bank_debouncer.sv
// Directed bench for button_bank_debouncer with short timing constants.
module tb_button_bank_debouncer;

  localparam int unsigned N = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] button;
  logic [N-1:0] repeat_en;
  logic [N-1:0] db, press, rel, rpt;
  logic         any_press;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int n_press;

  button_bank_debouncer #(
    .N_CH         (5),
    .STABLE_CYCLES(4),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(3),
    .INVERT       (5'b00010)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .button_i   (button),
    .repeat_en_i(repeat_en),
    .db_o       (db),
    .press_o    (press),
    .release_o  (rel),
    .repeat_o   (rpt),
    .any_press_o(any_press)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [4:0] bounce_seq [9];
    bounce_seq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    // Reset with toggling buttons
    reset     = 1'b1;
    button    = '0;
    repeat_en = '0;
    for (int i = 0; i < 3; i++) begin
      button = 5'(i * 7 + 5);
      tick();
    end
    check("reset_outs", 32'({db, press, rel, rpt, any_press}), 32'h0);
    button = 5'b00010;
    reset  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("idle_outs", 32'({db, press, rel, rpt, any_press}), 32'h0);
    end

    // Clean press on channel 0, first sampled at edge 0
    button[0] = 1'b1;
    for (int e = 0; e < 5; e++) begin
      tick();
      check("press0_early_db", 32'(db[0]), 32'h0);
    end
    tick();
    check("press0_db", 32'(db[0]), 32'h1);
    check("press0_strobe", 32'(press), 32'h01);
    check("press0_any_lag", 32'(any_press), 32'h0);
    tick();
    check("press0_strobe_end", 32'(press), 32'h00);
    check("press0_any", 32'(any_press), 32'h1);
    tick();
    check("press0_any_end", 32'(any_press), 32'h0);

    // Clean release on channel 0
    button[0] = 1'b0;
    for (int e = 0; e < 5; e++) tick();
    check("rel0_early", 32'(rel), 32'h00);
    tick();
    check("rel0_strobe", 32'(rel), 32'h01);
    check("rel0_db", 32'(db[0]), 32'h0);
    tick();
    check("rel0_strobe_end", 32'(rel), 32'h00);

    // Bounce filter on channel 2: high 3, low 1, then steady high
    n_press   = 0;
    button[2] = 1'b1;
    for (int e = 0; e < 3; e++) begin tick(); n_press += int'(press[2]); end
    button[2] = 1'b0;
    tick(); n_press += int'(press[2]);
    button[2] = 1'b1;
    for (int e = 0; e < 5; e++) begin tick(); n_press += int'(press[2]); end
    check("bounce2_no_early", 32'(press[2]), 32'h0);
    check("bounce2_db_low", 32'(db[2]), 32'h0);
    tick(); n_press += int'(press[2]);
    check("bounce2_press", 32'(press[2]), 32'h1);
    check("bounce2_db", 32'(db[2]), 32'h1);
    for (int e = 0; e < 5; e++) begin tick(); n_press += int'(press[2]); end
    check("bounce2_one_press", 32'(n_press), 32'h1);

    // Auto-repeat on channel 3
    repeat_en[3] = 1'b1;
    button[3]    = 1'b1;
    for (int e = 0; e < 5; e++) tick();
    tick();
    check("rep3_press", 32'(press[3]), 32'h1);
    for (int e = 6; e <= 21; e++) begin
      tick();
      check($sformatf("rep3_e%0d", e), 32'(rpt[3]), 32'((e == 15) || (e == 18) || (e == 21)));
    end
    repeat_en[3] = 1'b0;
    tick();
    check("rep3_disabled", 32'(rpt[3]), 32'h0);
    repeat_en[3] = 1'b1;
    for (int e = 23; e <= 32; e++) begin
      tick();
      check($sformatf("rep3_restart_e%0d", e), 32'(rpt[3]), 32'(e == 32));
    end
    button[3]    = 1'b0;
    repeat_en[3] = 1'b0;
    for (int e = 0; e < 8; e++) tick();
    check("rep3_released", 32'(db[3]), 32'h0);

    // Inverted channel 1: press by driving low, then release with a bounce
    button[1] = 1'b0;
    for (int e = 0; e < 7; e++) tick();
    check("inv1_db", 32'(db[1]), 32'h1);
    for (int e = 0; e < 9; e++) begin
      button[1] = bounce_seq[e][0];
      tick();
      check($sformatf("inv1_hold_e%0d", e), 32'({db[1], rel[1]}), 32'h2);
    end
    tick();
    check("inv1_release", 32'({db[1], rel[1]}), 32'h1);
    tick();
    check("inv1_release_end", 32'(rel[1]), 32'h0);

    // Simultaneous presses on channels 0 and 4
    button[0] = 1'b1;
    button[4] = 1'b1;
    for (int e = 0; e < 5; e++) tick();
    tick();
    check("simul_press", 32'(press), 32'h11);
    tick();
    check("simul_any", 32'(any_press), 32'h1);
    check("simul_db", 32'(db), 32'h15);

    // Reset while held: no release strobe, all outputs cleared
    reset = 1'b1;
    tick();
    check("rst_hold_outs", 32'({db, press, rel, rpt, any_press}), 32'h0);
    button = 5'b00010;
    tick();
    tick();
    reset = 1'b0;
    for (int e = 0; e < 8; e++) begin
      tick();
      check("post_rst_quiet", 32'({db, rel}), 32'h0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
